trdb_word_buffer: RTL

Elastic buffer directly downstream of the trace debugger's packet output. It accepts 32-bit packet words over the valid/grant handshake and answers with `grant_o`, replacing the randomized grant the bench drives today. It stores the words in a circular FIFO and presents them in order on a valid/ready stream toward the streamer/APB readout. Optional statistics counters expose throughput and back-pressure.

---
 rtl/trdb_pkg.sv | 22 ++
 rtl/trdb_sat_counter.sv | 45 ++++
 rtl/trdb_word_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/trdb_pkg.sv
// ============================================================================
// Module      : trdb_pkg
// Description : Shared widths, default depth and word type for the trace
//               debugger word buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trdb_pkg;

  // Packet word width produced by the trace debugger
  localparam int unsigned TRDB_WORD_W            = 32;
  // Default elastic buffer depth (power of two, at least 2)
  localparam int unsigned TRDB_BUF_DEPTH_DEFAULT = 8;
  // Width of every statistics counter
  localparam int unsigned TRDB_STAT_W            = 32;

  typedef logic [TRDB_WORD_W-1:0] trdb_word_t;

endpackage : trdb_pkg

`default_nettype wire

// File: rtl/trdb_sat_counter.sv
// ============================================================================
// Module      : trdb_sat_counter
// Description : Statistics counter that increments on enable and sticks at
//               all-ones. Only elaborated when TRDB_WORD_BUFFER_STATS_EN is
//               defined, so no counter logic exists in the default build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef TRDB_WORD_BUFFER_STATS_EN
module trdb_sat_counter
  import trdb_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  output logic [TRDB_STAT_W-1:0] count_o
);

  logic [TRDB_STAT_W-1:0] count_q;
  logic [TRDB_STAT_W-1:0] count_d;

  // Increment on enable unless already saturated at all-ones
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + TRDB_STAT_W'(1);
    end
  end

  // Counter register, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : trdb_sat_counter
`endif

`default_nettype wire

// File: rtl/trdb_word_buffer.sv
// ============================================================================
// Module      : trdb_word_buffer
// Description : Circular FIFO between the trace debugger packet output
//               (valid/grant) and the readout stream (valid/ready).
//               Optional statistics counters are enabled by defining the
//               macro TRDB_WORD_BUFFER_STATS_EN; otherwise the statistics
//               ports read zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trdb_word_buffer
  import trdb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TRDB_WORD_W,
  parameter int unsigned DEPTH      = TRDB_BUF_DEPTH_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [DATA_WIDTH-1:0]    packet_word_i,
  input  logic                     packet_word_valid_i,
  output logic                     grant_o,
  output logic [DATA_WIDTH-1:0]    out_word_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic [TRDB_STAT_W-1:0]   words_in_o,
  output logic [TRDB_STAT_W-1:0]   words_out_o,
  output logic [TRDB_STAT_W-1:0]   stall_cycles_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;

  // Grant depends only on registered fill and flush: a pop in the same cycle
  // does not open a slot for a full FIFO, keeping out_ready_i off this path.
  assign w_full      = (count_q == CNT_W'(DEPTH));
  assign grant_o     = !w_full && !flush_i;
  assign w_push      = packet_word_valid_i && grant_o;
  assign out_valid_o = (count_q != '0);
  assign w_pop       = out_valid_o && out_ready_i && !flush_i;
  assign out_word_o  = mem_q[rptr_q];
  assign fill_o      = count_q;

  // Next pointers and count; flush discards any push or pop of this cycle
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) begin
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and count state, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents survive reset and flush
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wptr_q] <= packet_word_i;
    end
  end

`ifdef TRDB_WORD_BUFFER_STATS_EN
  logic w_stall;
  assign w_stall = packet_word_valid_i && !grant_o;

  trdb_sat_counter u_words_in (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (w_push),
    .count_o (words_in_o)
  );

  trdb_sat_counter u_words_out (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (w_pop),
    .count_o (words_out_o)
  );

  trdb_sat_counter u_stall_cycles (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (w_stall),
    .count_o (stall_cycles_o)
  );
`else
  assign words_in_o     = '0;
  assign words_out_o    = '0;
  assign stall_cycles_o = '0;
`endif

endmodule : trdb_word_buffer

`default_nettype wire
